// File: rtl/weight_kernel_pkg.sv
// Shared types and helpers for the weight kernel bank.
// Optional build macro WEIGHT_BANK_DEFAULT_INIT_EN: both banks reset to DEFAULT_WEIGHT.
package weight_kernel_pkg;

  // Load/swap controller states.
  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } state_t;

  // Reset value of every tap when default initialisation is enabled.
  localparam logic signed [7:0] DEFAULT_WEIGHT = 8'sh20;

  function automatic int taps(input int kh, input int kw);
    return kh * kw;
  endfunction

  function automatic int total(input int nk, input int kh, input int kw);
    return nk * kh * kw;
  endfunction

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/weight_kernel_regfile.sv
// NK x TAPS register bank: single-word write port, whole-bank parallel load
// and full parallel read. Parallel load has priority over the word write.
module weight_kernel_regfile
  import weight_kernel_pkg::*;
#(
  parameter int NK = 4,
  parameter int TAPS = 9,
  parameter int WW = 8,
  parameter logic [WW-1:0] INIT = '0
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we,
  input  logic [idx_width(NK)-1:0]           wk,
  input  logic [idx_width(TAPS)-1:0]         wt,
  input  logic [WW-1:0]                      wdata,
  input  logic                               ld,
  input  logic [NK-1:0][TAPS-1:0][WW-1:0]    ld_data,
  output logic [NK-1:0][TAPS-1:0][WW-1:0]    rd_data
);

  // Storage: reset to INIT, bulk copy on ld, otherwise single addressed write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NK; k++)
        for (int t = 0; t < TAPS; t++)
          rd_data[k][t] <= INIT;
    end else if (ld) begin
      rd_data <= ld_data;
    end else if (we) begin
      for (int k = 0; k < NK; k++)
        for (int t = 0; t < TAPS; t++)
          if (32'(wk) == k && 32'(wt) == t)
            rd_data[k][t] <= wdata;
    end
  end

endmodule

// File: rtl/weight_kernel_bank.sv
// Double-buffered conv kernel store. Words stream into the shadow bank; a swap
// in FULL copies shadow to active. The selected active kernel is registered
// onto weight_o with tap [0][0] at the LSBs.
// Optional build macro WEIGHT_BANK_DEFAULT_INIT_EN: banks reset to
// DEFAULT_WEIGHT and weight_valid_out resets high.
//
// Load handshake: a word is taken on a rising clk_in edge when
// load_valid_in && load_ready_out; load_ready_out is high only in LOAD and
// outside reset, and does not depend on load_valid_in.
module weight_kernel_bank
  import weight_kernel_pkg::*;
#(
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int NUM_KERNELS   = 4
) (
  input  logic                                  clk_in,
  input  logic                                  rst_in,
  input  logic                                  load_valid_in,
  output logic                                  load_ready_out,
  input  logic [WEIGHT_WIDTH-1:0]               load_data_in,
  input  logic                                  load_last_in,
  output logic                                  load_err_out,
  input  logic                                  err_clr_in,
  input  logic                                  swap_req_in,
  output logic                                  swap_ack_out,
  input  logic [idx_width(NUM_KERNELS)-1:0]     kernel_sel_in,
  output logic                                  weight_valid_out,
  output logic signed [KERNEL_HEIGHT-1:0][KERNEL_WIDTH-1:0][WEIGHT_WIDTH-1:0] weight_o,
  output state_t                                dbg_state
);

  localparam int TAPS_N  = taps(KERNEL_HEIGHT, KERNEL_WIDTH);
  localparam int TOTAL_N = total(NUM_KERNELS, KERNEL_HEIGHT, KERNEL_WIDTH);
  localparam int CW      = idx_width(TOTAL_N);
  localparam int KSW     = idx_width(NUM_KERNELS);
  localparam int TSW     = idx_width(TAPS_N);
  localparam logic [CW-1:0] LAST_CNT = CW'(TOTAL_N - 1);

`ifdef WEIGHT_BANK_DEFAULT_INIT_EN
  localparam logic [WEIGHT_WIDTH-1:0] INIT_W = WEIGHT_WIDTH'(DEFAULT_WEIGHT);
  localparam logic VALID_RST = 1'b1;
`else
  localparam logic [WEIGHT_WIDTH-1:0] INIT_W = '0;
  localparam logic VALID_RST = 1'b0;
`endif

  typedef logic [NUM_KERNELS-1:0][TAPS_N-1:0][WEIGHT_WIDTH-1:0] bank_t;
  typedef logic [TAPS_N-1:0][WEIGHT_WIDTH-1:0] kernel_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_d, ack_d, valid_d;
  logic          accept, at_end, swap_do;
  logic [KSW-1:0] wr_k;
  logic [TSW-1:0] wr_t;
  bank_t         shadow_rd, active_rd;
  kernel_t       sel_kernel;

  assign load_ready_out = (state_q == LOAD) && !rst_in;
  assign accept         = load_valid_in && load_ready_out;
  assign at_end         = (cnt_q == LAST_CNT);
  assign wr_k           = KSW'(32'(cnt_q) / TAPS_N);
  assign wr_t           = TSW'(32'(cnt_q) % TAPS_N);
  assign dbg_state      = state_q;

  // Controller registers: state, word counter, sticky error, ack pulse, valid flag.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q          <= LOAD;
      cnt_q            <= '0;
      load_err_out     <= 1'b0;
      swap_ack_out     <= 1'b0;
      weight_valid_out <= VALID_RST;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      load_err_out     <= err_d;
      swap_ack_out     <= ack_d;
      weight_valid_out <= valid_d;
    end
  end

  // Next-state logic: framing check on each accepted word, swap only from FULL.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = load_err_out;
    ack_d   = 1'b0;
    valid_d = weight_valid_out;
    swap_do = 1'b0;
    // Clear first so an error detected this cycle still sets the flag.
    if (err_clr_in) err_d = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (load_last_in && at_end) begin
            state_d = FULL;
            cnt_d   = '0;
          end else if (load_last_in || at_end) begin
            err_d = 1'b1;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (swap_req_in) begin
          swap_do = 1'b1;
          ack_d   = 1'b1;
          valid_d = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  weight_kernel_regfile #(
    .NK(NUM_KERNELS), .TAPS(TAPS_N), .WW(WEIGHT_WIDTH), .INIT(INIT_W)
  ) u_shadow (
    .clk(clk_in), .rst(rst_in),
    .we(accept), .wk(wr_k), .wt(wr_t), .wdata(load_data_in),
    .ld(1'b0), .ld_data('0),
    .rd_data(shadow_rd)
  );

  weight_kernel_regfile #(
    .NK(NUM_KERNELS), .TAPS(TAPS_N), .WW(WEIGHT_WIDTH), .INIT(INIT_W)
  ) u_active (
    .clk(clk_in), .rst(rst_in),
    .we(1'b0), .wk('0), .wt('0), .wdata('0),
    .ld(swap_do), .ld_data(shadow_rd),
    .rd_data(active_rd)
  );

  // Kernel select: out-of-range indices yield an all-zero kernel.
  always_comb begin
    sel_kernel = '0;
    for (int k = 0; k < NUM_KERNELS; k++)
      if (32'(kernel_sel_in) == k) sel_kernel = active_rd[k];
  end

  // Output register: one cycle from kernel_sel_in to weight_o.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) weight_o <= '0;
    else        weight_o <= sel_kernel;
  end

endmodule

// File: tb/tb_weight_kernel_bank.sv
// Self-checking bench for weight_kernel_bank: directed scenarios plus a random
// phase, compared every cycle against a word-array reference model.
module tb_weight_kernel_bank;
  import weight_kernel_pkg::*;

  localparam int KH = 3, KW = 3, WW = 8, NK = 4;
  localparam int TAPS = KH * KW;
  localparam int TOTAL = NK * TAPS;
  localparam int SW = 2;
  localparam int KB = TAPS * WW;

  logic clk, rst_in;
  logic load_valid_in, load_ready_out, load_last_in, load_err_out;
  logic [WW-1:0] load_data_in;
  logic err_clr_in, swap_req_in, swap_ack_out, weight_valid_out;
  logic [SW-1:0] kernel_sel_in;
  logic [KH-1:0][KW-1:0][WW-1:0] weight_o;
  state_t dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: flat word arrays indexed kernel*TAPS + tap.
  logic [WW-1:0] shadow_m[TOTAL];
  logic [WW-1:0] active_m[TOTAL];
  bit full_m, err_m, valid_m, ack_m;
  int cnt_m;
  logic [KB-1:0] exp_q[$];

  weight_kernel_bank #(
    .KERNEL_WIDTH(KW), .KERNEL_HEIGHT(KH), .WEIGHT_WIDTH(WW), .NUM_KERNELS(NK)
  ) dut (
    .clk_in(clk), .rst_in(rst_in),
    .load_valid_in(load_valid_in), .load_ready_out(load_ready_out),
    .load_data_in(load_data_in), .load_last_in(load_last_in),
    .load_err_out(load_err_out), .err_clr_in(err_clr_in),
    .swap_req_in(swap_req_in), .swap_ack_out(swap_ack_out),
    .kernel_sel_in(kernel_sel_in), .weight_valid_out(weight_valid_out),
    .weight_o(weight_o), .dbg_state(dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    logic [WW-1:0] iv;
`ifdef WEIGHT_BANK_DEFAULT_INIT_EN
    iv = 8'h20;
    valid_m = 1'b1;
`else
    iv = '0;
    valid_m = 1'b0;
`endif
    for (int i = 0; i < TOTAL; i++) begin
      shadow_m[i] = iv;
      active_m[i] = iv;
    end
    full_m = 0; err_m = 0; ack_m = 0; cnt_m = 0;
    exp_q.delete();
  endtask

  // One rising edge of the reference model, using the inputs currently driven.
  task automatic model_update();
    logic [KB-1:0] w;
    w = '0;
    if (int'(kernel_sel_in) < NK)
      for (int t = 0; t < TAPS; t++)
        w[t*WW +: WW] = active_m[int'(kernel_sel_in) * TAPS + t];
    exp_q.push_back(w);
    ack_m = 0;
    if (err_clr_in) err_m = 0;
    if (!full_m) begin
      if (load_valid_in) begin
        shadow_m[cnt_m] = load_data_in;
        if (load_last_in && cnt_m == TOTAL - 1) begin
          full_m = 1; cnt_m = 0;
        end else if (load_last_in || cnt_m == TOTAL - 1) begin
          err_m = 1; cnt_m = 0;
        end else begin
          cnt_m++;
        end
      end
    end else if (swap_req_in) begin
      for (int i = 0; i < TOTAL; i++) active_m[i] = shadow_m[i];
      ack_m = 1; valid_m = 1; full_m = 0;
    end
  endtask

  // Advance one cycle and compare every output on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    check("ready", load_ready_out, !full_m);
    check("err", load_err_out, err_m);
    check("ack", swap_ack_out, ack_m);
    check("valid", weight_valid_out, valid_m);
    if (exp_q.size() > 0) check("weight", weight_o, exp_q.pop_front());
  endtask

  task automatic set_idle();
    load_valid_in = 0; load_last_in = 0; swap_req_in = 0; err_clr_in = 0;
  endtask

  // Driver: mode 0 = words 1..n, 1 = random with gaps, 2 = -128/127 alternating.
  task automatic load_seq(input int n, input int last_at, input int mode);
    for (int i = 0; i < n; i++) begin
      if (mode == 1 && $urandom_range(0, 3) == 0) begin
        load_valid_in = 0; load_last_in = 0;
        tick();
      end
      load_valid_in = 1;
      load_last_in = (i == last_at);
      case (mode)
        0: load_data_in = WW'(i + 1);
        1: load_data_in = WW'($urandom);
        default: load_data_in = (i % 2 == 1) ? 8'h7f : 8'h80;
      endcase
      tick();
    end
    load_valid_in = 0; load_last_in = 0;
  endtask

  task automatic do_swap();
    swap_req_in = 1;
    tick();
    swap_req_in = 0;
    tick();
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_ready"}, load_ready_out, 1'b0);
    check({tag, "_err"}, load_err_out, 1'b0);
    check({tag, "_ack"}, swap_ack_out, 1'b0);
    check({tag, "_valid"}, weight_valid_out, valid_m);
    check({tag, "_weight"}, weight_o, '0);
  endtask

  initial begin
    rst_in = 1; set_idle(); kernel_sel_in = 0; load_data_in = 0;
    model_reset();
    repeat (2) @(negedge clk);
    reset_checks("rst");
    rst_in = 0;
    #1;
    check("ready_after_rst", load_ready_out, 1'b1);

    // Sequential load 1..36, swap, read kernels 0 and 3.
    load_seq(TOTAL, TOTAL - 1, 0);
    do_swap();
    kernel_sel_in = 0;
    tick(); tick();
    check("k0_w00", weight_o[0][0], 8'd1);
    check("k0_w22", weight_o[2][2], 8'd9);
    kernel_sel_in = 3;
    tick();
    check("k3_w22", weight_o[2][2], 8'd36);

    // Early last -> framing error, active untouched, then clear and reload.
    load_seq(5, 4, 1);
    check("err_set", load_err_out, 1'b1);
    check("ready_after_err", load_ready_out, 1'b1);
    tick();
    check("active_kept", weight_o[2][2], 8'd36);
    err_clr_in = 1; tick(); err_clr_in = 0;
    check("err_cleared", load_err_out, 1'b0);
    load_seq(TOTAL, TOTAL - 1, 1);
    do_swap();

    // FULL back-pressure, then a single-cycle ack.
    load_seq(TOTAL, TOTAL - 1, 1);
    load_valid_in = 1; load_data_in = WW'($urandom);
    repeat (3) tick();
    check("ready_full", load_ready_out, 1'b0);
    load_valid_in = 0; swap_req_in = 1;
    tick();
    check("ack_rise", swap_ack_out, 1'b1);
    swap_req_in = 0;
    tick();
    check("ack_fall", swap_ack_out, 1'b0);
    check("ready_back", load_ready_out, 1'b1);

    // Swap held through a whole load: ignored until the first FULL cycle.
    swap_req_in = 1;
    load_seq(TOTAL, TOTAL - 1, 1);
    check("no_ack_final_word", swap_ack_out, 1'b0);
    tick();
    check("ack_first_full", swap_ack_out, 1'b1);
    swap_req_in = 0;
    tick();

    // Reset in the middle of a load, then a fresh load from word 0.
    load_seq(20, -1, 1);
    rst_in = 1;
    #1;
    model_reset();
    reset_checks("midrst");
    @(negedge clk);
    rst_in = 0;
    load_seq(TOTAL, TOTAL - 1, 1);
    do_swap();

    // Extreme values, select changes every cycle.
    load_seq(TOTAL, TOTAL - 1, 2);
    do_swap();
    for (int i = 0; i < 12; i++) begin
      int k;
      k = $urandom_range(0, NK - 1);
      kernel_sel_in = SW'(k);
      tick();
      check("sign_w00", weight_o[0][0], (k % 2 == 1) ? 8'h7f : 8'h80);
    end

    // Random traffic, mostly well-framed.
    for (int i = 0; i < 600; i++) begin
      load_valid_in = 1'($urandom_range(0, 1));
      load_data_in = WW'($urandom);
      load_last_in = ($urandom_range(0, 15) == 0) ? 1'($urandom_range(0, 1))
                                                  : (cnt_m == TOTAL - 1);
      swap_req_in = ($urandom_range(0, 3) == 0);
      err_clr_in = ($urandom_range(0, 7) == 0);
      kernel_sel_in = SW'($urandom_range(0, NK - 1));
      tick();
    end
    set_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
